// File: rtl/router_nport.sv
// router_nport: single-stream packet router feeding N_PORTS output channels.
// Each packet is a header (addr/len), len payload bytes and one XOR parity
// byte. Good packets are stored whole in the destination FIFO. Packets with
// an illegal address or zero length are swallowed. Any channel left unread
// for TIMEOUT cycles is flushed.
module router_nport #(
  parameter int N_PORTS    = 3,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           d_in,
  input  logic                        pkt_valid,
  output logic                        busy,
  output logic                        err,
  input  logic [N_PORTS-1:0]          rd_en,
  output logic [N_PORTS-1:0]          vld_out,
  output logic [N_PORTS*DATA_W-1:0]   dout
);

  localparam int ADDR_W = (N_PORTS <= 2) ? 1 : $clog2(N_PORTS);
  localparam int LEN_W  = DATA_W - ADDR_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int SEL_N  = 2 ** ADDR_W;

  localparam logic [ADDR_W:0]   N_PORTS_C = N_PORTS[ADDR_W:0];
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0]  TIMEOUT_C = TMR_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, DROP} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  dest, dest_nxt;
  logic [LEN_W-1:0]   remaining, remaining_nxt;
  logic [DATA_W-1:0]  parity, parity_nxt;
  logic               err_nxt;

  logic [ADDR_W-1:0]  hdr_addr;
  logic [LEN_W-1:0]   hdr_len;
  logic               hdr_ok;
  logic               accept;
  logic               wr_any;
  logic [ADDR_W-1:0]  wr_port;
  // Full flags padded to every encodable address so a header index never
  // selects past the end; unused slots read as not full.
  logic [SEL_N-1:0]   full;

  assign hdr_addr = d_in[ADDR_W-1:0];
  assign hdr_len  = d_in[DATA_W-1:ADDR_W];
  assign hdr_ok   = ({1'b0, hdr_addr} < N_PORTS_C) && (hdr_len != '0);
  assign accept   = pkt_valid && !busy;
  assign wr_port  = (state == IDLE) ? hdr_addr : dest;
  assign wr_any   = accept && (((state == IDLE) && hdr_ok) ||
                               (state == DATA) || (state == PARITY));

  // Back-pressure: only when the word about to be stored has no room.
  always_comb begin
    busy = 1'b0;
    unique case (state)
      IDLE:        busy = pkt_valid && hdr_ok && full[hdr_addr];
      DATA,
      PARITY:      busy = full[dest];
      default:     busy = 1'b0;
    endcase
  end

  // Packet FSM next-state: header decode, payload count, parity check.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt     = state;
    dest_nxt      = dest;
    remaining_nxt = remaining;
    parity_nxt    = parity;
    err_nxt       = err;
    if (accept) begin
      unique case (state)
        IDLE: begin
          remaining_nxt = hdr_len;
          if (hdr_ok) begin
            dest_nxt   = hdr_addr;
            parity_nxt = d_in;
            err_nxt    = 1'b0;
            state_nxt  = DATA;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = DROP;
          end
        end
        DATA: begin
          parity_nxt    = parity ^ d_in;
          remaining_nxt = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) state_nxt = PARITY;
        end
        PARITY: begin
          err_nxt   = (d_in != parity);
          state_nxt = IDLE;
        end
        DROP: begin
          if (remaining == '0) state_nxt = IDLE;
          else                 remaining_nxt = remaining - LEN_W'(1);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Packet FSM state register; reset discards any partial packet.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dest      <= '0;
      remaining <= '0;
      parity    <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      dest      <= dest_nxt;
      remaining <= remaining_nxt;
      parity    <= parity_nxt;
      err       <= err_nxt;
    end
  end

  for (genvar s = N_PORTS; s < SEL_N; s++) begin : g_pad
    assign full[s] = 1'b0;
  end

  for (genvar i = 0; i < N_PORTS; i++) begin : g_ch
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [TMR_W-1:0]  timer;
    logic              push, pop, active, flush;

    assign push   = wr_any && (wr_port == ADDR_W'(i));
    assign pop    = rd_en[i] && (count != '0);
    assign active = ((state == DATA) || (state == PARITY)) && (dest == ADDR_W'(i));
    assign flush  = (timer == TIMEOUT_C) && !active;

    assign full[i]    = (count == DEPTH_C);
    assign vld_out[i] = (count != '0);
    assign dout[i*DATA_W +: DATA_W] = (count != '0) ? mem[rd_ptr] : '0;

    // Storage array; a push coinciding with a flush lands in slot 0.
    // NOTE: the data array is not reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
      if (push) mem[flush ? '0 : wr_ptr] <= d_in;
    end

    // Pointer and occupancy tracking; flush empties the channel outright.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= push ? PTR_W'(1) : '0;
        count  <= push ? CNT_W'(1) : '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end

    // Idle-reader watchdog; saturates while the channel is being written.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                timer <= '0;
      else if (flush || pop || count == '0)   timer <= '0;
      else if (timer != TIMEOUT_C)            timer <= timer + TMR_W'(1);
    end
  end

endmodule

// File: tb/tb_router_nport.sv
// tb_router_nport: directed scenarios for router_nport with hand-computed
// expected byte streams. Inputs change just after the rising edge, outputs
// are sampled on the falling edge or 1ns after the rising edge.
module tb_router_nport;

  localparam int N = 3;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   d_in;
  logic           pkt_valid;
  logic           busy;
  logic           err;
  logic [N-1:0]   rd_en;
  logic [N-1:0]   vld_out;
  logic [N*W-1:0] dout;

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] got [$];
  logic         busy_seen;

  router_nport #(.N_PORTS(N), .DATA_W(W), .FIFO_DEPTH(16), .TIMEOUT(30)) dut (
    .clk       (clk),
    .rst       (rst),
    .d_in      (d_in),
    .pkt_valid (pkt_valid),
    .busy      (busy),
    .err       (err),
    .rd_en     (rd_en),
    .vld_out   (vld_out),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  // Present one byte and hold it until accepted; returns 1ns after the edge.
  task automatic send(input logic [W-1:0] b);
    int waited = 0;
    d_in = b;
    pkt_valid = 1'b1;
    @(negedge clk);
    while (busy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (busy) begin
      n_assert++;
      n_fail++;
      $display("FAIL send_accept: busy=%b still high after %0d cycles, required 0", busy, waited);
    end
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
  endtask

  // Record every word popped from a port until n words or budget cycles.
  task automatic collect(input int port, input int n, input int budget);
    got.delete();
    busy_seen = 1'b0;
    for (int c = 0; c < budget && got.size() < n; c++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (vld_out[port] && rd_en[port]) got.push_back(dout[port*W +: W]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; d_in = '0; pkt_valid = 1'b0; rd_en = '0;
    #12;
    n_assert++; if (vld_out !== '0) begin n_fail++; $display("FAIL reset_vld: got %b required 000", vld_out); end
    n_assert++; if (dout !== '0)    begin n_fail++; $display("FAIL reset_dout: got %h required 0", dout); end
    n_assert++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_assert++; if (err !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Port 1, len 4, reader always ready.
  task automatic test_basic();
    logic [W-1:0] exp [$];
    logic [W-1:0] act;
    exp = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rd_en = 3'b010;
    fork
      for (int k = 0; k < 6; k++) send(exp[k]);
      collect(1, 6, 40);
    join
    @(posedge clk); #1; rd_en = '0;
    n_assert++; if (got.size() != 6) begin n_fail++; $display("FAIL basic_count: got %0d words required 6", got.size()); end
    for (int k = 0; k < 6; k++) begin
      act = (k < got.size()) ? got[k] : 8'hxx;
      n_assert++; if (act !== exp[k]) begin n_fail++; $display("FAIL basic_word%0d: got %h required %h", k, act, exp[k]); end
    end
    n_assert++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL basic_busy: busy seen %b required 0", busy_seen); end
    n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b required 0", err); end
  endtask

  // Port 2, len 20 into a 16-deep FIFO with the reader stalled.
  task automatic test_back_pressure();
    logic [W-1:0] exp [$];
    logic [W-1:0] act;
    logic [W-1:0] p;
    exp.push_back(8'h52);
    p = 8'h52;
    for (int k = 1; k <= 20; k++) begin
      exp.push_back(W'(k));
      p = p ^ W'(k);
    end
    exp.push_back(p);
    rd_en = '0;
    for (int k = 0; k < 16; k++) send(exp[k]);
    d_in = exp[16]; pkt_valid = 1'b1;
    @(negedge clk);
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy_rise: got %b required 1", busy); end
    n_assert++; if (dout[2*W +: W] !== 8'h52) begin n_fail++; $display("FAIL bp_head: got %h required 52", dout[2*W +: W]); end
    repeat (3) @(negedge clk);
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy_hold: got %b required 1", busy); end
    @(posedge clk); #1;
    rd_en = 3'b100;
    fork
      for (int k = 16; k < 22; k++) send(exp[k]);
      collect(2, 22, 120);
    join
    @(posedge clk); #1; rd_en = '0;
    n_assert++; if (got.size() != 22) begin n_fail++; $display("FAIL bp_count: got %0d words required 22", got.size()); end
    for (int k = 0; k < 22; k++) begin
      act = (k < got.size()) ? got[k] : 8'hxx;
      n_assert++; if (act !== exp[k]) begin n_fail++; $display("FAIL bp_word%0d: got %h required %h", k, act, exp[k]); end
    end
    n_assert++; if (vld_out !== '0) begin n_fail++; $display("FAIL bp_empty: got %b required 000", vld_out); end
  endtask

  // Port 0 with a corrupted parity byte (correct parity F7, sent F6).
  task automatic test_parity_err();
    logic [W-1:0] exp [$];
    logic [W-1:0] act;
    exp = '{8'h08, 8'hA5, 8'h5A, 8'hF6};
    rd_en = '0;
    for (int k = 0; k < 4; k++) send(exp[k]);
    n_assert++; if (err !== 1'b1) begin n_fail++; $display("FAIL par_err_set: got %b required 1", err); end
    n_assert++; if (vld_out !== 3'b001) begin n_fail++; $display("FAIL par_stored: got %b required 001", vld_out); end
    rd_en = 3'b001;
    collect(0, 4, 20);
    @(posedge clk); #1; rd_en = '0;
    for (int k = 0; k < 4; k++) begin
      act = (k < got.size()) ? got[k] : 8'hxx;
      n_assert++; if (act !== exp[k]) begin n_fail++; $display("FAIL par_word%0d: got %h required %h", k, act, exp[k]); end
    end
    n_assert++; if (err !== 1'b1) begin n_fail++; $display("FAIL par_err_hold: got %b required 1", err); end
    send(8'h05);
    n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL par_err_clear: got %b required 0", err); end
    send(8'h66);
    send(8'h63);
    n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL par_good_after: got %b required 0", err); end
    rd_en = 3'b010;
    collect(1, 3, 20);
    @(posedge clk); #1; rd_en = '0;
    n_assert++; if (got.size() != 3) begin n_fail++; $display("FAIL par_p1_count: got %0d words required 3", got.size()); end
  endtask

  // Illegal address 3, len 2: three more bytes are swallowed.
  task automatic test_bad_addr();
    logic [W-1:0] exp [$];
    logic [W-1:0] act;
    logic [W-1:0] drop_bytes [3];
    drop_bytes = '{8'hDE, 8'hAD, 8'hBE};
    rd_en = '0;
    send(8'h0B);
    n_assert++; if (err !== 1'b1) begin n_fail++; $display("FAIL drop_err: got %b required 1", err); end
    for (int k = 0; k < 3; k++) begin
      send(drop_bytes[k]);
      n_assert++; if (vld_out !== '0) begin n_fail++; $display("FAIL drop_vld%0d: got %b required 000", k, vld_out); end
    end
    n_assert++; if (err !== 1'b1) begin n_fail++; $display("FAIL drop_err_hold: got %b required 1", err); end
    exp = '{8'h04, 8'h77, 8'h73};
    send(exp[0]);
    n_assert++; if (err !== 1'b0 || vld_out !== 3'b001) begin
      n_fail++; $display("FAIL drop_next_hdr: got err=%b vld=%b required err=0 vld=001", err, vld_out);
    end
    send(exp[1]);
    send(exp[2]);
    n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL drop_next_err: got %b required 0", err); end
    rd_en = 3'b001;
    collect(0, 3, 20);
    @(posedge clk); #1; rd_en = '0;
    for (int k = 0; k < 3; k++) begin
      act = (k < got.size()) ? got[k] : 8'hxx;
      n_assert++; if (act !== exp[k]) begin n_fail++; $display("FAIL drop_word%0d: got %h required %h", k, act, exp[k]); end
    end
  endtask

  // Unread port 0 is flushed 31 edges after its header edge.
  task automatic test_timeout();
    logic [W-1:0] pkt [5];
    pkt = '{8'h0C, 8'h01, 8'h02, 8'h03, 8'h0C};
    rd_en = '0;
    for (int k = 0; k < 5; k++) send(pkt[k]);
    repeat (26) @(posedge clk);
    #1;
    n_assert++; if (vld_out[0] !== 1'b1) begin n_fail++; $display("FAIL tmo_before: vld0 got %b required 1", vld_out[0]); end
    @(posedge clk); #1;
    n_assert++; if (vld_out[0] !== 1'b0) begin n_fail++; $display("FAIL tmo_flush: vld0 got %b required 0", vld_out[0]); end
    n_assert++; if (dout[0 +: W] !== '0) begin n_fail++; $display("FAIL tmo_dout: got %h required 00", dout[0 +: W]); end
  endtask

  // Reset in the middle of a port-1 packet, then a clean port-2 packet.
  task automatic test_mid_reset();
    logic [W-1:0] exp [$];
    logic [W-1:0] act;
    rd_en = '0;
    send(8'h0D);
    send(8'hAA);
    n_assert++; if (vld_out[1] !== 1'b1) begin n_fail++; $display("FAIL mrst_pre: vld1 got %b required 1", vld_out[1]); end
    rst = 1'b1;
    #1;
    n_assert++; if (vld_out !== '0 || dout !== '0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL mrst_outputs: vld=%b dout=%h busy=%b err=%b required all 0", vld_out, dout, busy, err);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    exp = '{8'h06, 8'h99, 8'h9F};
    for (int k = 0; k < 3; k++) send(exp[k]);
    n_assert++; if (err !== 1'b0 || vld_out !== 3'b100) begin
      n_fail++; $display("FAIL mrst_route: got err=%b vld=%b required err=0 vld=100", err, vld_out);
    end
    rd_en = 3'b100;
    collect(2, 3, 20);
    @(posedge clk); #1; rd_en = '0;
    for (int k = 0; k < 3; k++) begin
      act = (k < got.size()) ? got[k] : 8'hxx;
      n_assert++; if (act !== exp[k]) begin n_fail++; $display("FAIL mrst_word%0d: got %h required %h", k, act, exp[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_parity_err();
    test_bad_addr();
    test_timeout();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
